// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, drives the program ROM address,
// tags each returned word with its address and an on-path flag, and keeps a
// small return-address stack for CALL/RET and interrupts.
module fetch_sequencer #(
    parameter int unsigned        ADDR_W     = 10,
    parameter int unsigned        RAS_DEPTH  = 8,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = 10'h000,
    parameter logic [ADDR_W-1:0]  INT_VECTOR = 10'h3FF,
    localparam int unsigned       SP_W       = $clog2(RAS_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              STALL,
    input  logic              BR_EN,
    input  logic [ADDR_W-1:0] BR_ADDR,
    input  logic              CALL_EN,
    input  logic              RET_EN,
    input  logic              INT_REQ,
    output logic [ADDR_W-1:0] PROG_ADDR,
    output logic [ADDR_W-1:0] IR_ADDR,
    output logic              FETCH_VALID,
    output logic [SP_W-1:0]   SP_LEVEL,
    output logic              STACK_ERR
);

    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic              take_int;
    logic              take_ret;
    logic              take_call;
    logic              take_br;
    logic              redirect;
    logic              stack_full;
    logic              stack_empty;
    logic              push_ok;
    logic [ADDR_W-1:0] push_data;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    logic [ADDR_W-1:0] pc_d;
    logic [SP_W-1:0]   sp_d;
    logic              err_d;
    logic              valid_d;

    // Commands only count when they come from an on-path word; resolve priority.
    always_comb begin
        take_int    = FETCH_VALID & INT_REQ;
        take_ret    = FETCH_VALID & RET_EN & ~INT_REQ;
        take_call   = FETCH_VALID & CALL_EN & ~INT_REQ & ~RET_EN;
        take_br     = FETCH_VALID & BR_EN & ~INT_REQ & ~RET_EN & ~CALL_EN;
        redirect    = take_int | take_ret | take_call | take_br;
        stack_full  = (SP_LEVEL == SP_W'(RAS_DEPTH));
        stack_empty = (SP_LEVEL == '0);
        // Interrupt re-executes the interrupted word; CALL returns past itself.
        push_data   = take_int ? IR_ADDR : IR_ADDR + ADDR_W'(1);
        push_ok     = (take_int | take_call) & ~stack_full;
        push_idx    = IDX_W'(SP_LEVEL);
        pop_idx     = IDX_W'(SP_LEVEL - SP_W'(1));
    end

    // Next PC, stack pointer, sticky error and on-path flag.
    always_comb begin
        pc_d    = PROG_ADDR + ADDR_W'(1);
        sp_d    = SP_LEVEL;
        err_d   = STACK_ERR;
        valid_d = ~(redirect | STALL);
        if (take_int) begin
            pc_d = INT_VECTOR;
        end else if (take_ret) begin
            pc_d = stack_empty ? RESET_ADDR : ras_q[pop_idx];
        end else if (take_call | take_br) begin
            pc_d = BR_ADDR;
        end else if (STALL) begin
            pc_d = PROG_ADDR;
        end
        if (take_int | take_call) begin
            if (stack_full) begin
                err_d = 1'b1;
            end else begin
                sp_d = SP_LEVEL + SP_W'(1);
            end
        end else if (take_ret) begin
            if (stack_empty) begin
                err_d = 1'b1;
            end else begin
                sp_d = SP_LEVEL - SP_W'(1);
            end
        end
    end

    // Architectural state with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            PROG_ADDR   <= RESET_ADDR;
            IR_ADDR     <= RESET_ADDR;
            FETCH_VALID <= 1'b0;
            SP_LEVEL    <= '0;
            STACK_ERR   <= 1'b0;
        end else begin
            PROG_ADDR   <= pc_d;
            IR_ADDR     <= PROG_ADDR;
            FETCH_VALID <= valid_d;
            SP_LEVEL    <= sp_d;
            STACK_ERR   <= err_d;
        end
    end

    // Stack storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (RST_N && push_ok) begin
            ras_q[push_idx] <= push_data;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, free-run, branch, call/return,
// stack overflow/underflow, interrupt priority, wrap, and stall handling.
module tb_fetch_sequencer;

    logic       CLK;
    logic       RST_N;
    logic       STALL;
    logic       BR_EN;
    logic [9:0] BR_ADDR;
    logic       CALL_EN;
    logic       RET_EN;
    logic       INT_REQ;
    logic [9:0] PROG_ADDR;
    logic [9:0] IR_ADDR;
    logic       FETCH_VALID;
    logic [3:0] SP_LEVEL;
    logic       STACK_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(
        .ADDR_W     (10),
        .RAS_DEPTH  (8),
        .RESET_ADDR (10'h000),
        .INT_VECTOR (10'h3FF)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .STALL       (STALL),
        .BR_EN       (BR_EN),
        .BR_ADDR     (BR_ADDR),
        .CALL_EN     (CALL_EN),
        .RET_EN      (RET_EN),
        .INT_REQ     (INT_REQ),
        .PROG_ADDR   (PROG_ADDR),
        .IR_ADDR     (IR_ADDR),
        .FETCH_VALID (FETCH_VALID),
        .SP_LEVEL    (SP_LEVEL),
        .STACK_ERR   (STACK_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge and settle before sampling / driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [9:0] pc, input logic [9:0] ir,
                             input logic fv);
        chk({tag, ".pc"}, {22'd0, PROG_ADDR}, {22'd0, pc});
        chk({tag, ".ir"}, {22'd0, IR_ADDR}, {22'd0, ir});
        chk({tag, ".fv"}, {31'd0, FETCH_VALID}, {31'd0, fv});
    endtask

    task automatic chk_stack(input string tag, input logic [3:0] sp, input logic err);
        chk({tag, ".sp"}, {28'd0, SP_LEVEL}, {28'd0, sp});
        chk({tag, ".err"}, {31'd0, STACK_ERR}, {31'd0, err});
    endtask

    initial begin
        RST_N = 1'b0; STALL = 1'b0; BR_EN = 1'b0; BR_ADDR = '0;
        CALL_EN = 1'b0; RET_EN = 1'b0; INT_REQ = 1'b0;
        tick();
        chk_fetch("reset", 10'h000, 10'h000, 1'b0);
        chk_stack("reset", 4'd0, 1'b0);
        RST_N = 1'b1;

        // Free-run: IR lags PC by one, valid from the first post-reset edge.
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_fetch("freerun", 10'(i), 10'(i - 1), 1'b1);
        end
        tick();
        tick();
        chk_fetch("pre_br", 10'h006, 10'h005, 1'b1);

        // Branch from 0x005 to 0x120; a branch on the bubble must be ignored.
        BR_EN = 1'b1; BR_ADDR = 10'h120;
        tick();
        chk_fetch("br_bubble", 10'h120, 10'h006, 1'b0);
        BR_ADDR = 10'h2AA;
        tick();
        chk_fetch("br_land", 10'h121, 10'h120, 1'b1);

        // Get to 0x010, then nested CALLs and RETs.
        BR_ADDR = 10'h010;
        tick();
        BR_EN = 1'b0;
        tick();
        chk_fetch("at_010", 10'h011, 10'h010, 1'b1);
        CALL_EN = 1'b1; BR_ADDR = 10'h200;
        tick();
        CALL_EN = 1'b0;
        chk_fetch("call1", 10'h200, 10'h011, 1'b0);
        chk_stack("call1", 4'd1, 1'b0);
        tick();
        tick();
        chk_fetch("at_201", 10'h202, 10'h201, 1'b1);
        CALL_EN = 1'b1; BR_ADDR = 10'h300;
        tick();
        CALL_EN = 1'b0;
        chk_fetch("call2", 10'h300, 10'h202, 1'b0);
        chk_stack("call2", 4'd2, 1'b0);
        tick();
        RET_EN = 1'b1;
        tick();
        RET_EN = 1'b0;
        chk_fetch("ret1", 10'h202, 10'h301, 1'b0);
        chk_stack("ret1", 4'd1, 1'b0);
        tick();
        chk_fetch("ret1_land", 10'h203, 10'h202, 1'b1);
        RET_EN = 1'b1;
        tick();
        RET_EN = 1'b0;
        chk_fetch("ret2", 10'h011, 10'h203, 1'b0);
        chk_stack("ret2", 4'd0, 1'b0);
        tick();
        chk_fetch("ret2_land", 10'h012, 10'h011, 1'b1);

        // Nine CALLs into an eight-deep stack: saturate and flag.
        for (int i = 0; i < 9; i++) begin
            CALL_EN = 1'b1; BR_ADDR = 10'h100;
            tick();
            CALL_EN = 1'b0;
            chk("ovf.pc", {22'd0, PROG_ADDR}, 32'h100);
            chk_stack("ovf", (i < 8) ? 4'(i + 1) : 4'd8, (i == 8));
            tick();
        end

        // Reset with a full, errored stack.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk_fetch("rst_full", 10'h000, 10'h000, 1'b0);
        chk_stack("rst_full", 4'd0, 1'b0);
        tick();
        RET_EN = 1'b1;
        tick();
        RET_EN = 1'b0;
        chk_fetch("undf", 10'h000, 10'h001, 1'b0);
        chk_stack("undf", 4'd0, 1'b1);
        tick();
        chk_fetch("undf_land", 10'h001, 10'h000, 1'b1);
        chk_stack("undf_sticky", 4'd0, 1'b1);

        // Interrupt beats CALL and BR in the same cycle; 0x3FF wraps to 0x000.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        BR_EN = 1'b1; BR_ADDR = 10'h040;
        tick();
        BR_EN = 1'b0;
        tick();
        chk_fetch("at_040", 10'h041, 10'h040, 1'b1);
        INT_REQ = 1'b1; CALL_EN = 1'b1; BR_EN = 1'b1; BR_ADDR = 10'h155;
        tick();
        INT_REQ = 1'b0; CALL_EN = 1'b0; BR_EN = 1'b0;
        chk_fetch("int", 10'h3FF, 10'h041, 1'b0);
        chk_stack("int", 4'd1, 1'b0);
        tick();
        chk_fetch("wrap", 10'h000, 10'h3FF, 1'b1);
        RET_EN = 1'b1;
        tick();
        RET_EN = 1'b0;
        chk_fetch("reti", 10'h040, 10'h000, 1'b0);
        chk_stack("reti", 4'd0, 1'b0);
        tick();
        chk_fetch("reti_land", 10'h041, 10'h040, 1'b1);

        // Stall three cycles with PC at 0x050.
        BR_EN = 1'b1; BR_ADDR = 10'h04F;
        tick();
        BR_EN = 1'b0;
        tick();
        chk_fetch("at_04f", 10'h050, 10'h04F, 1'b1);
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fetch("stall", 10'h050, 10'h050, 1'b0);
        end
        STALL = 1'b0;
        tick();
        chk_fetch("unstall", 10'h051, 10'h050, 1'b1);
        tick();
        chk_fetch("unstall2", 10'h052, 10'h051, 1'b1);

        // A branch raised together with STALL still redirects.
        STALL = 1'b1; BR_EN = 1'b1; BR_ADDR = 10'h0A0;
        tick();
        BR_EN = 1'b0;
        chk_fetch("stall_br", 10'h0A0, 10'h052, 1'b0);
        tick();
        chk_fetch("stall_br_hold", 10'h0A0, 10'h0A0, 1'b0);
        STALL = 1'b0;
        tick();
        chk_fetch("stall_br_land", 10'h0A1, 10'h0A0, 1'b1);

        // Reset mid-stall with a pushed entry and a pending branch.
        CALL_EN = 1'b1; BR_ADDR = 10'h0C0;
        tick();
        CALL_EN = 1'b0;
        chk_stack("pre_rst", 4'd1, 1'b0);
        STALL = 1'b1;
        tick();
        chk_fetch("pre_rst", 10'h0C0, 10'h0C0, 1'b0);
        RST_N = 1'b0; BR_EN = 1'b1; BR_ADDR = 10'h1EE;
        tick();
        chk_fetch("rst_stall", 10'h000, 10'h000, 1'b0);
        chk_stack("rst_stall", 4'd0, 1'b0);
        RST_N = 1'b1; STALL = 1'b0; BR_EN = 1'b0;
        tick();
        chk_fetch("post_rst", 10'h001, 10'h000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
